// File: rtl/shift_operand_stage_if.sv
// shift_operand_stage_if: instruction/operand bundle between
// the register-file read stage, the operand stage and the shifter.
interface shift_operand_stage_if;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] RD2;
  logic        RsSel;
  logic        OutValid;
  logic [1:0]  Sh;
  logic [4:0]  Shamt5;
  logic [31:0] ShIn;
  logic        ShAmtBig;

  modport master (
    output InValid,
    output Instr,
    output RD2,
    input  InReady,
    input  RsSel,
    input  OutValid,
    input  Sh,
    input  Shamt5,
    input  ShIn,
    input  ShAmtBig
  );

  modport slave (
    input  InValid,
    input  Instr,
    input  RD2,
    output InReady,
    output RsSel,
    output OutValid,
    output Sh,
    output Shamt5,
    output ShIn,
    output ShAmtBig
  );
endinterface

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: decodes the Src2 field and registers
// the barrel-shifter operands (Sh, Shamt5, ShIn, ShAmtBig).
module shift_operand_stage #(
  parameter bit REG_SHIFT_EN = 1'b1
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Stall,
  input  logic Flush,
  shift_operand_stage_if.slave bus
);

  typedef enum logic {
    IDLE,
    RS_FETCH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rm_q, rm_d;
  logic [1:0]  rsh_q, rsh_d;
  logic        vld_q, vld_d;
  logic [1:0]  sh_q, sh_d;
  logic [4:0]  amt_q, amt_d;
  logic [31:0] shin_q, shin_d;
  logic        big_q, big_d;

  logic in_ready;
  logic accept;
  logic is_imm;
  logic is_reg;
  logic unused_bits;

  // Only bit 25 and bits 11:0 of the instruction matter here.
  assign unused_bits = ^{bus.Instr[31:26], bus.Instr[24:12]};

  assign in_ready = (state_q == IDLE) & ~Stall;
  assign accept   = bus.InValid & in_ready;
  assign is_imm   = bus.Instr[25];
  assign is_reg   = ~bus.Instr[25] & bus.Instr[4] & REG_SHIFT_EN;

  assign bus.InReady  = in_ready;
  assign bus.RsSel    = (state_q == RS_FETCH);
  assign bus.OutValid = vld_q;
  assign bus.Sh       = sh_q;
  assign bus.Shamt5   = amt_q;
  assign bus.ShIn     = shin_q;
  assign bus.ShAmtBig = big_q;

  // Next state: Flush beats Stall beats decode; data outputs
  // only move when a result is actually produced.
  always_comb begin
    state_d = state_q;
    rm_d    = rm_q;
    rsh_d   = rsh_q;
    vld_d   = vld_q;
    sh_d    = sh_q;
    amt_d   = amt_q;
    shin_d  = shin_q;
    big_d   = big_q;
    if (Flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      rm_d    = '0;
      rsh_d   = '0;
    end else if (!Stall) begin
      unique case (state_q)
        IDLE: begin
          vld_d = 1'b0;
          if (accept) begin
            unique case (1'b1)
              is_imm: begin
                shin_d = {24'b0, bus.Instr[7:0]};
                sh_d   = 2'b11;
                amt_d  = {bus.Instr[11:8], 1'b0};
                big_d  = 1'b0;
                vld_d  = 1'b1;
              end
              is_reg: begin
                rm_d    = bus.RD2;
                rsh_d   = bus.Instr[6:5];
                state_d = RS_FETCH;
              end
              default: begin
                shin_d = bus.RD2;
                sh_d   = bus.Instr[6:5];
                amt_d  = bus.Instr[11:7];
                big_d  = 1'b0;
                vld_d  = 1'b1;
              end
            endcase
          end
        end
        RS_FETCH: begin
          // RD2 now carries Rs; only its low byte is the amount.
          amt_d   = bus.RD2[4:0];
          big_d   = |bus.RD2[7:5];
          shin_d  = rm_q;
          sh_d    = rsh_q;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      rm_q    <= '0;
      rsh_q   <= '0;
      vld_q   <= 1'b0;
      sh_q    <= '0;
      amt_q   <= '0;
      shin_q  <= '0;
      big_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rm_q    <= rm_d;
      rsh_q   <= rsh_d;
      vld_q   <= vld_d;
      sh_q    <= sh_d;
      amt_q   <= amt_d;
      shin_q  <= shin_d;
      big_q   <= big_d;
    end
  end

endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage: directed vectors, scoreboard queues
// and per-instance monitors for both parameter builds.
module tb_shift_operand_stage;

  typedef struct packed {
    logic [1:0]  sh;
    logic [4:0]  amt;
    logic [31:0] shin;
    logic        big;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  logic Stall;
  logic Flush;

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 CLK = ~CLK;

  shift_operand_stage_if a_if();
  shift_operand_stage_if b_if();

  shift_operand_stage #(.REG_SHIFT_EN(1'b1)) dut_a (
    .CLK   (CLK),
    .Reset (Reset),
    .Stall (Stall),
    .Flush (Flush),
    .bus   (a_if.slave)
  );

  shift_operand_stage #(.REG_SHIFT_EN(1'b0)) dut_b (
    .CLK   (CLK),
    .Reset (Reset),
    .Stall (Stall),
    .Flush (Flush),
    .bus   (b_if.slave)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor A: pop on each freshly produced valid result.
  always @(posedge CLK) begin
    logic stl, rst;
    exp_t got, e;
    stl = Stall;
    rst = Reset;
    #2;
    if (a_if.OutValid && !stl && !rst) begin
      got = '{a_if.Sh, a_if.Shamt5, a_if.ShIn, a_if.ShAmtBig};
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_extra: got %h want none", got);
      end else begin
        e = qa.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL a_out: got %h want %h", got, e);
        end
      end
    end
  end

  // Monitor B: same for the build without register shifts.
  always @(posedge CLK) begin
    logic stl, rst;
    exp_t got, e;
    stl = Stall;
    rst = Reset;
    #2;
    if (b_if.OutValid && !stl && !rst) begin
      got = '{b_if.Sh, b_if.Shamt5, b_if.ShIn, b_if.ShAmtBig};
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_extra: got %h want none", got);
      end else begin
        e = qb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL b_out: got %h want %h", got, e);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_vld"}, 32'(a_if.OutValid), 32'd0);
    chk({nm, "_sh"}, 32'(a_if.Sh), 32'd0);
    chk({nm, "_amt"}, 32'(a_if.Shamt5), 32'd0);
    chk({nm, "_shin"}, a_if.ShIn, 32'd0);
    chk({nm, "_big"}, 32'(a_if.ShAmtBig), 32'd0);
    chk({nm, "_rssel"}, 32'(a_if.RsSel), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    Flush = 1'b0;
    a_if.InValid = 1'b0;
    a_if.Instr   = '0;
    a_if.RD2     = '0;
    b_if.InValid = 1'b0;
    b_if.Instr   = '0;
    b_if.RD2     = '0;
    tick();
    tick();
    chk_zero("rst");
    Reset = 1'b0;
    tick();

    // Rotated immediate: rot=4 -> Shamt5=8, ROR.
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'h02A0_04FF;
    a_if.RD2     = 32'h5555_AAAA;
    qa.push_back('{2'b11, 5'd8, 32'h0000_00FF, 1'b0});
    tick();
    chk("imm_ready", 32'(a_if.InReady), 32'd1);

    // Immediate shift, back to back: ASR #3.
    a_if.Instr = 32'hE1A0_01C0;
    a_if.RD2   = 32'h8000_0010;
    qa.push_back('{2'b10, 5'd3, 32'h8000_0010, 1'b0});
    tick();
    chk("ish_vld", 32'(a_if.OutValid), 32'd1);

    // Register shift LSR by Rs=0x24.
    a_if.Instr = 32'hE1A0_0230;
    a_if.RD2   = 32'h1234_5678;
    tick();
    a_if.RD2 = 32'h0000_0024;
    #1;
    chk("rs1_rssel", 32'(a_if.RsSel), 32'd1);
    chk("rs1_ready", 32'(a_if.InReady), 32'd0);
    chk("rs1_vld", 32'(a_if.OutValid), 32'd0);
    qa.push_back('{2'b01, 5'd4, 32'h1234_5678, 1'b1});
    tick();
    a_if.InValid = 1'b0;
    #1;
    chk("rs2_rssel", 32'(a_if.RsSel), 32'd0);
    chk("rs2_vld", 32'(a_if.OutValid), 32'd1);

    // Register shift ASR, stalled 3 cycles in RS_FETCH.
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'hE1A0_0250;
    a_if.RD2     = 32'hCAFE_0001;
    tick();
    a_if.InValid = 1'b0;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.RD2 = 32'h0000_00FF;
      tick();
      chk("stl_rssel", 32'(a_if.RsSel), 32'd1);
      chk("stl_ready", 32'(a_if.InReady), 32'd0);
      chk("stl_vld", 32'(a_if.OutValid), 32'd0);
    end
    Stall = 1'b0;
    a_if.RD2 = 32'h0000_0107;
    qa.push_back('{2'b10, 5'd7, 32'hCAFE_0001, 1'b0});
    tick();
    chk("stl_done_rssel", 32'(a_if.RsSel), 32'd0);

    // Valid result held across a stall in IDLE.
    Stall = 1'b1;
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'h02A0_0011;
    #1;
    chk("hold_ready", 32'(a_if.InReady), 32'd0);
    tick();
    chk("hold_vld", 32'(a_if.OutValid), 32'd1);
    chk("hold_shin", a_if.ShIn, 32'hCAFE_0001);
    Stall = 1'b0;
    a_if.InValid = 1'b0;
    tick();
    chk("idle_vld", 32'(a_if.OutValid), 32'd0);
    chk("idle_shin", a_if.ShIn, 32'hCAFE_0001);

    // Flush with Stall during RS_FETCH.
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'hE1A0_0230;
    a_if.RD2     = 32'h1111_1111;
    tick();
    a_if.InValid = 1'b0;
    Stall = 1'b1;
    Flush = 1'b1;
    tick();
    Stall = 1'b0;
    Flush = 1'b0;
    #1;
    chk("fl_rssel", 32'(a_if.RsSel), 32'd0);
    chk("fl_ready", 32'(a_if.InReady), 32'd1);
    chk("fl_vld", 32'(a_if.OutValid), 32'd0);
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'h02A0_0F12;
    qa.push_back('{2'b11, 5'd30, 32'h0000_0012, 1'b0});
    tick();

    // Flush drops a simultaneous accept.
    Flush = 1'b1;
    a_if.Instr = 32'h02A0_0133;
    tick();
    Flush = 1'b0;
    a_if.InValid = 1'b0;
    chk("fla_vld", 32'(a_if.OutValid), 32'd0);
    chk("fla_shin", a_if.ShIn, 32'h0000_0012);

    // Build without register shifts: bit 4 ignored.
    b_if.InValid = 1'b1;
    b_if.Instr   = 32'hE1A0_02F0;
    b_if.RD2     = 32'hDEAD_BEEF;
    qb.push_back('{2'b11, 5'd5, 32'hDEAD_BEEF, 1'b0});
    tick();
    b_if.InValid = 1'b0;
    chk("b_rssel", 32'(b_if.RsSel), 32'd0);
    chk("b_ready", 32'(b_if.InReady), 32'd1);
    chk("b_vld", 32'(b_if.OutValid), 32'd1);
    tick();

    // Reset in the middle of RS_FETCH.
    a_if.InValid = 1'b1;
    a_if.Instr   = 32'hE1A0_0270;
    a_if.RD2     = 32'h0F0F_0F0F;
    tick();
    a_if.InValid = 1'b0;
    chk("mid_rssel", 32'(a_if.RsSel), 32'd1);
    Reset = 1'b1;
    a_if.RD2 = 32'h0000_0003;
    tick();
    chk_zero("mrst");
    chk("mrst_ready", 32'(a_if.InReady), 32'd1);
    Reset = 1'b0;
    tick();
    tick();

    chk("qa_left", 32'(qa.size()), 32'd0);
    chk("qb_left", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
